// File: rtl/io_port_pkg.sv
// ----------------------------------------------------------------------------
// io_port_pkg
// Shared constants and helpers for the CPU I/O port peripheral.
//   IO_WORD_W     : default data width of every port word
//   IO_FIFO_DEPTH : default number of out-FIFO entries (power of two, >= 2)
//   clog2()       : pointer width for a given depth, usable in constant context
// ----------------------------------------------------------------------------
package io_port_pkg;

  localparam int IO_WORD_W     = 32;
  localparam int IO_FIFO_DEPTH = 4;

  // Smallest n with 2**n >= value; value 1 yields 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// ----------------------------------------------------------------------------
// io_sync_fifo
// Single-clock FIFO buffering CPU OUT words toward the host stream.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset (empties the FIFO)
//   i_push         : write request; accepted when not full or when popping
//   i_pop          : read request; ignored when empty
//   i_wr_data      : word written on an accepted push
//   o_rd_data      : head entry (combinational read of mem[rd_ptr])
//   o_valid        : FIFO holds at least one entry
//   o_full         : FIFO holds DEPTH entries
//   o_count        : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module io_sync_fifo
  import io_port_pkg::*;
#(
  parameter int WORD_W = IO_WORD_W,
  parameter int DEPTH  = IO_FIFO_DEPTH
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [WORD_W-1:0]         i_wr_data,
  output logic [WORD_W-1:0]         o_rd_data,
  output logic                      o_valid,
  output logic                      o_full,
  output logic [clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full = (r_count == CNT_W'(DEPTH));
  // Guards keep count within 0..DEPTH even if the caller misbehaves.
  assign w_pop  = i_pop & (r_count != {CNT_W{1'b0}});
  assign w_push = i_push & (~w_full | w_pop);

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_valid   = (r_count != {CNT_W{1'b0}});
  assign o_full    = w_full;
  assign o_count   = r_count;

  // Storage array: written on accepted push, deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is 2**PTR_W.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_peripheral.sv
// ----------------------------------------------------------------------------
// io_port_peripheral
// Device-side end of the CPU I/O ports. CPU OUT words are buffered in a FIFO
// and drained to the host stream; one host word is held for CPU IN. stop_req
// stalls the CPU on OUT-when-full or IN-when-empty.
// Build option: define IO_LOOPBACK_EN to add the 1-bit loopback input, which
// routes the FIFO head into the IN holding register instead of the host.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   out_wr, outport_data       : CPU OUT strobe (held until accepted) and word
//   in_rd, inport_in           : CPU IN strobe (held until accepted) and word
//   stop_req                   : CPU must hold the current IN/OUT this cycle
//   host_out_data/valid/ready  : out stream toward host (pop on valid&ready)
//   host_in_data/valid/ready   : in stream from host (load on valid&ready)
//   loopback (IO_LOOPBACK_EN)  : 1 = FIFO head feeds the IN register
// ----------------------------------------------------------------------------
module io_port_peripheral
  import io_port_pkg::*;
#(
  parameter int WORD_W = IO_WORD_W,
  parameter int DEPTH  = IO_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_wr,
  input  logic [WORD_W-1:0] outport_data,
  input  logic              in_rd,
  output logic [WORD_W-1:0] inport_in,
  output logic              stop_req,
  output logic [WORD_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  input  logic [WORD_W-1:0] host_in_data,
  input  logic              host_in_valid,
`ifdef IO_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              host_in_ready
);

  localparam int CNT_W = clog2(DEPTH) + 1;

  logic              r_in_full;
  logic [WORD_W-1:0] r_in_reg;

  logic [WORD_W-1:0] w_fifo_head;
  logic              w_fifo_valid;
  logic              w_fifo_full;
  logic [CNT_W-1:0]  w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_consume;
  logic              w_in_space;
  logic              w_load;
  logic [WORD_W-1:0] w_load_data;

  io_sync_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (outport_data),
    .o_rd_data (w_fifo_head),
    .o_valid   (w_fifo_valid),
    .o_full    (w_fifo_full),
    .o_count   (w_count)
  );

  assign w_consume  = in_rd & r_in_full;
  // Holding register can take a new word if empty or being emptied this cycle.
  assign w_in_space = ~r_in_full | w_consume;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = out_wr & (~w_fifo_full | w_pop);

  assign host_out_data = w_fifo_head;
  assign inport_in     = r_in_reg;
  assign stop_req      = (out_wr & ~w_push) | (in_rd & ~r_in_full);

`ifdef IO_LOOPBACK_EN
  // Source select for the IN register and the FIFO pop: host or loopback.
  always_comb begin
    host_in_ready  = 1'b0;
    host_out_valid = 1'b0;
    w_load         = 1'b0;
    w_load_data    = host_in_data;
    w_pop          = 1'b0;
    if (loopback) begin
      w_load      = w_fifo_valid & w_in_space;
      w_load_data = w_fifo_head;
      w_pop       = w_load;
    end else begin
      host_in_ready  = w_in_space;
      host_out_valid = w_fifo_valid;
      w_load         = host_in_valid & w_in_space;
      w_load_data    = host_in_data;
      w_pop          = w_fifo_valid & host_out_ready;
    end
  end
`else
  assign host_in_ready  = w_in_space;
  assign host_out_valid = w_fifo_valid;
  assign w_load         = host_in_valid & w_in_space;
  assign w_load_data    = host_in_data;
  assign w_pop          = w_fifo_valid & host_out_ready;
`endif

  // IN holding register: a load wins over a same-cycle consume so full stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_full <= 1'b0;
      r_in_reg  <= {WORD_W{1'b0}};
    end else if (w_load) begin
      r_in_full <= 1'b1;
      r_in_reg  <= w_load_data;
    end else if (w_consume) begin
      r_in_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_port_peripheral.sv
module tb_io_port_peripheral;

  logic        clk;
  logic        reset;
  logic        out_wr;
  logic [31:0] outport_data;
  logic        in_rd;
  logic [31:0] inport_in;
  logic        stop_req;
  logic [31:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic [31:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
`ifdef IO_LOOPBACK_EN
  logic        loopback;
`endif

  int n_checks;
  int n_errors;

  io_port_peripheral #(
    .WORD_W (32),
    .DEPTH  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .out_wr         (out_wr),
    .outport_data   (outport_data),
    .in_rd          (in_rd),
    .inport_in      (inport_in),
    .stop_req       (stop_req),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
`ifdef IO_LOOPBACK_EN
    .loopback       (loopback),
`endif
    .host_in_ready  (host_in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the expected one.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so registered state has settled.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // The CPU never issues OUT and IN in the same cycle.
  always @(posedge clk) begin
    if (!reset && out_wr && in_rd) begin
      n_errors++;
      $display("FAIL illegal_out_wr_and_in_rd at %0t", $time);
    end
  end

  logic [31:0] model_q[$];
  logic [31:0] t2_words[4];

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    out_wr         = 1'b0;
    outport_data   = 32'h0;
    in_rd          = 1'b0;
    host_out_ready = 1'b0;
    host_in_data   = 32'h0;
    host_in_valid  = 1'b0;
`ifdef IO_LOOPBACK_EN
    loopback       = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;

    // T1: load some content, then reset for 2 cycles mid-stream.
    out_wr = 1'b1; outport_data = 32'hAA; tick();
    out_wr = 1'b0;
    host_in_valid = 1'b1; host_in_data = 32'h99; tick();
    host_in_valid = 1'b0; #1;
    check_eq("t1_pre_inport", inport_in, 32'h99);
    check_eq("t1_pre_valid", {31'b0, host_out_valid}, 32'd1);
    reset = 1'b1; tick(); tick();
    reset = 1'b0; #1;
    check_eq("t1_valid", {31'b0, host_out_valid}, 32'd0);
    check_eq("t1_inport", inport_in, 32'h0);
    check_eq("t1_in_ready", {31'b0, host_in_ready}, 32'd1);
    check_eq("t1_stop", {31'b0, stop_req}, 32'd0);
    check_eq("t1_count", 32'(dut.w_count), 32'd0);

    // T2: burst of 4 with host not ready, then a 5th that must stall.
    t2_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      out_wr = 1'b1; outport_data = t2_words[i]; #1;
      check_eq("t2_stop_fill", {31'b0, stop_req}, 32'd0);
      tick();
    end
    out_wr = 1'b0; #1;
    check_eq("t2_count4", 32'(dut.w_count), 32'd4);
    check_eq("t2_head", host_out_data, 32'h11);
    out_wr = 1'b1; outport_data = 32'h55; #1;
    check_eq("t2_stop_full", {31'b0, stop_req}, 32'd1);
    tick();
    check_eq("t2_stop_held", {31'b0, stop_req}, 32'd1);
    check_eq("t2_count_held", 32'(dut.w_count), 32'd4);
    host_out_ready = 1'b1; #1;
    check_eq("t2_stop_release", {31'b0, stop_req}, 32'd0);
    check_eq("t2_pop0", host_out_data, 32'h11);
    tick();
    out_wr = 1'b0;
    model_q = '{32'h22, 32'h33, 32'h44, 32'h55};
    foreach (model_q[i]) begin
      #1;
      check_eq("t2_pop_valid", {31'b0, host_out_valid}, 32'd1);
      check_eq("t2_pop_data", host_out_data, model_q[i]);
      tick();
    end
    host_out_ready = 1'b0; #1;
    check_eq("t2_empty", {31'b0, host_out_valid}, 32'd0);

    // T3: full FIFO, simultaneous push and pop for 3 laps.
    model_q = {};
    for (int i = 0; i < 4; i++) begin
      out_wr = 1'b1; outport_data = 32'h100 + 32'(i);
      model_q.push_back(32'h100 + 32'(i));
      tick();
    end
    out_wr = 1'b0; #1;
    check_eq("t3_count_full", 32'(dut.w_count), 32'd4);
    host_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      out_wr = 1'b1; outport_data = 32'h200 + 32'(i); #1;
      check_eq("t3_stop", {31'b0, stop_req}, 32'd0);
      check_eq("t3_head", host_out_data, model_q[0]);
      void'(model_q.pop_front());
      model_q.push_back(32'h200 + 32'(i));
      tick();
      check_eq("t3_count", 32'(dut.w_count), 32'd4);
    end
    out_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t3_drain", host_out_data, model_q[i]);
      tick();
    end
    host_out_ready = 1'b0; #1;
    check_eq("t3_drained", {31'b0, host_out_valid}, 32'd0);

    // T4: IN with empty holding register stalls until the host supplies a word.
    in_rd = 1'b1; #1;
    check_eq("t4_stop_empty", {31'b0, stop_req}, 32'd1);
    host_in_valid = 1'b1; host_in_data = 32'hDEADBEEF; #1;
    check_eq("t4_in_ready", {31'b0, host_in_ready}, 32'd1);
    check_eq("t4_stop_same_cycle", {31'b0, stop_req}, 32'd1);
    tick();
    host_in_valid = 1'b0; in_rd = 1'b0; #1;
    check_eq("t4_inport", inport_in, 32'hDEADBEEF);
    check_eq("t4_in_ready_full", {31'b0, host_in_ready}, 32'd0);
    in_rd = 1'b1; #1;
    check_eq("t4_stop_clear", {31'b0, stop_req}, 32'd0);
    check_eq("t4_in_ready_consume", {31'b0, host_in_ready}, 32'd1);

    // T5: consume and load in the same cycle keeps the register full.
    host_in_valid = 1'b1; host_in_data = 32'hCAFE0001; #1;
    tick();
    host_in_valid = 1'b0; #1;
    check_eq("t5_inport", inport_in, 32'hCAFE0001);
    check_eq("t5_stop_full", {31'b0, stop_req}, 32'd0);
    tick();
    #1;
    check_eq("t5_stop_after_consume", {31'b0, stop_req}, 32'd1);
    check_eq("t5_inport_hold", inport_in, 32'hCAFE0001);
    in_rd = 1'b0;

`ifdef IO_LOOPBACK_EN
    // T6: loopback routes an OUT word into the IN register two cycles later.
    loopback = 1'b1;
    out_wr = 1'b1; outport_data = 32'h1234; #1;
    check_eq("t6_in_ready", {31'b0, host_in_ready}, 32'd0);
    tick();
    out_wr = 1'b0; #1;
    check_eq("t6_valid_masked", {31'b0, host_out_valid}, 32'd0);
    tick();
    #1;
    check_eq("t6_inport", inport_in, 32'h1234);
    check_eq("t6_valid_after", {31'b0, host_out_valid}, 32'd0);
    check_eq("t6_count", 32'(dut.w_count), 32'd0);
    loopback = 1'b0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
